// File: rtl/reflet_mem_byte_bridge.sv
// reflet_mem_byte_bridge: runs one CPU word load/store as a sequence of byte cycles on an 8-bit synchronous RAM.
// Latency: store ready N+1 cycles after the req cycle, load ready N+2 (N = bytes in the access).
// Backpressure: no queue; req is sampled only in IDLE and requests arriving while busy are dropped.
// Optional: define REFLET_BRIDGE_ALIGN_CHECK_EN to reject misaligned multi-byte accesses with align_err.
module reflet_mem_byte_bridge #(
  parameter int wordsize = 16,
  parameter int addrsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                write_en,
  input  logic [1:0]          size_bits,
  input  logic [addrsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] data_out,
  output logic                busy,
  output logic                ready,
  output logic                align_err,
  output logic [addrsize-1:0] ram_addr,
  output logic [7:0]          ram_data_out,
  output logic                ram_write_en,
  input  logic [7:0]          ram_data_in
);

  localparam logic [3:0] WBYTES = 4'(wordsize / 8);

  typedef enum logic [1:0] {IDLE, XFER, RTAIL, DONE} state_t;

  state_t              state;
  logic [3:0]          count;
  logic [3:0]          nbytes;
  logic [3:0]          req_n;
  logic                is_store;
  logic [wordsize-1:0] wdata;
  logic [wordsize-1:0] rdata;
  logic                req_misaligned;

  // Byte count of the incoming request, clipped to the CPU word width.
  always_comb begin
    req_n = WBYTES;
    case (size_bits)
      2'b00:   req_n = WBYTES;
      2'b01:   req_n = (WBYTES < 4'd4) ? WBYTES : 4'd4;
      2'b10:   req_n = (WBYTES < 4'd2) ? WBYTES : 4'd2;
      default: req_n = 4'd1;
    endcase
  end

`ifdef REFLET_BRIDGE_ALIGN_CHECK_EN
  // N is a power of two, so N-1 on three bits is the offset mask (N=8 wraps to 7).
  assign req_misaligned = ((3'(addr) & (req_n[2:0] - 3'd1)) != 3'd0);
`else
  // Unaligned accesses simply run byte by byte with address wrap-around.
  assign req_misaligned = 1'b0;
`endif

  // Transfer sequencer; every interface output is a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      nbytes       <= 4'd0;
      is_store     <= 1'b0;
      wdata        <= '0;
      rdata        <= '0;
      data_out     <= '0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      align_err    <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= 8'd0;
      ram_write_en <= 1'b0;
    end else begin
      ready     <= 1'b0;
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (req_misaligned) begin
              state     <= DONE;
              ready     <= 1'b1;
              align_err <= 1'b1;
            end else begin
              // Byte 0 is presented to the RAM in the first XFER cycle.
              state        <= XFER;
              busy         <= 1'b1;
              count        <= 4'd0;
              nbytes       <= req_n;
              is_store     <= write_en;
              ram_addr     <= addr;
              ram_write_en <= write_en;
              ram_data_out <= data_in[7:0];
              wdata        <= data_in >> 8;
              rdata        <= '0;
            end
          end
        end
        XFER: begin
          // RAM read data lags the address by one cycle, so collect byte count-1.
          if (!is_store && count != 4'd0)
            rdata <= rdata | (wordsize'(ram_data_in) << {count - 4'd1, 3'b000});
          if (count == nbytes - 4'd1) begin
            ram_write_en <= 1'b0;
            if (is_store) begin
              state <= DONE;
              busy  <= 1'b0;
              ready <= 1'b1;
            end else begin
              state <= RTAIL;
            end
          end else begin
            count        <= count + 4'd1;
            ram_addr     <= ram_addr + addrsize'(1);
            ram_data_out <= wdata[7:0];
            wdata        <= wdata >> 8;
          end
        end
        RTAIL: begin
          // Final byte arrives now; untouched upper bytes of rdata are already zero.
          data_out <= rdata | (wordsize'(ram_data_in) << {count, 3'b000});
          state    <= DONE;
          busy     <= 1'b0;
          ready    <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_mem_byte_bridge.sv
// tb_reflet_mem_byte_bridge: directed checks of a 16-bit and a 32-bit bridge against byte RAM models.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_reflet_mem_byte_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- 16-bit instance ----------------
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [1:0]  a_size = 2'b00;
  logic [15:0] a_addr = 16'h0, a_din = 16'h0, a_dout;
  logic        a_busy, a_ready, a_align_err;
  logic [15:0] a_ram_addr;
  logic [7:0]  a_ram_dout, a_ram_din;
  logic        a_ram_we;
  logic [7:0]  mem_a [0:65535] = '{default: 8'h00};

  reflet_mem_byte_bridge #(.wordsize(16), .addrsize(16)) dut_a (
    .clk(clk), .reset(reset), .req(a_req), .write_en(a_we), .size_bits(a_size),
    .addr(a_addr), .data_in(a_din), .data_out(a_dout), .busy(a_busy), .ready(a_ready),
    .align_err(a_align_err), .ram_addr(a_ram_addr), .ram_data_out(a_ram_dout),
    .ram_write_en(a_ram_we), .ram_data_in(a_ram_din)
  );

  always @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_addr] <= a_ram_dout;
    a_ram_din <= mem_a[a_ram_addr];
  end

  // ---------------- 32-bit instance ----------------
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [1:0]  b_size = 2'b00;
  logic [15:0] b_addr = 16'h0;
  logic [31:0] b_din = 32'h0, b_dout;
  logic        b_busy, b_ready, b_align_err;
  logic [15:0] b_ram_addr;
  logic [7:0]  b_ram_dout, b_ram_din;
  logic        b_ram_we;
  logic [7:0]  mem_b [0:65535] = '{default: 8'h00};

  reflet_mem_byte_bridge #(.wordsize(32), .addrsize(16)) dut_b (
    .clk(clk), .reset(reset), .req(b_req), .write_en(b_we), .size_bits(b_size),
    .addr(b_addr), .data_in(b_din), .data_out(b_dout), .busy(b_busy), .ready(b_ready),
    .align_err(b_align_err), .ram_addr(b_ram_addr), .ram_data_out(b_ram_dout),
    .ram_write_en(b_ram_we), .ram_data_in(b_ram_din)
  );

  always @(posedge clk) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_dout;
    b_ram_din <= mem_b[b_ram_addr];
  end

  // Observations from the last transaction (cycle 1 = first cycle after req).
  int          rdy_cyc, wr_cnt, busy_cnt, err_at_rdy;
  logic [15:0] wr_addr [4];
  logic [7:0]  wr_dat  [4];
  int          wr_cyc  [4];

  task automatic a_txn(input logic we, input logic [1:0] sz, input logic [15:0] ad, input logic [15:0] d);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_size = sz; a_addr = ad; a_din = d;
    @(posedge clk); #1;
    a_req = 1'b0;
    rdy_cyc = -1; wr_cnt = 0; busy_cnt = 0; err_at_rdy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_ram_we) begin
        if (wr_cnt < 4) begin
          wr_addr[wr_cnt] = a_ram_addr; wr_dat[wr_cnt] = a_ram_dout; wr_cyc[wr_cnt] = c;
        end
        wr_cnt++;
      end
      if (a_busy) busy_cnt++;
      if (a_ready) begin
        rdy_cyc = c; err_at_rdy = int'(a_align_err);
        break;
      end
    end
  endtask

  task automatic b_txn(input logic we, input logic [1:0] sz, input logic [15:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    b_req = 1'b1; b_we = we; b_size = sz; b_addr = ad; b_din = d;
    @(posedge clk); #1;
    b_req = 1'b0;
    rdy_cyc = -1; wr_cnt = 0; busy_cnt = 0; err_at_rdy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_ram_we) begin
        if (wr_cnt < 4) begin
          wr_addr[wr_cnt] = b_ram_addr; wr_dat[wr_cnt] = b_ram_dout; wr_cyc[wr_cnt] = c;
        end
        wr_cnt++;
      end
      if (b_busy) busy_cnt++;
      if (b_ready) begin
        rdy_cyc = c; err_at_rdy = int'(b_align_err);
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #11;
    n_cmp++;
    if ({a_dout, a_busy, a_ready, a_align_err} !== 19'h0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", {a_dout, a_busy, a_ready, a_align_err});
    end
    n_cmp++;
    if ({a_ram_addr, a_ram_dout, a_ram_we} !== 25'h0) begin
      n_bad++; $display("FAIL reset_ram: got %h want 0", {a_ram_addr, a_ram_dout, a_ram_we});
    end
    n_cmp++;
    if ({b_dout, b_busy, b_ready, b_ram_we} !== 35'h0) begin
      n_bad++; $display("FAIL reset_b: got %h want 0", {b_dout, b_busy, b_ready, b_ram_we});
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_store_word;
    a_txn(1'b1, 2'b00, 16'h0010, 16'hBEEF);
    n_cmp++;
    if (rdy_cyc !== 3) begin n_bad++; $display("FAIL st_ready_cyc: got %0d want 3", rdy_cyc); end
    n_cmp++;
    if (wr_cnt !== 2) begin n_bad++; $display("FAIL st_wr_cnt: got %0d want 2", wr_cnt); end
    n_cmp++;
    if ({wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]} !== 48'h0010_EF_0011_BE) begin
      n_bad++; $display("FAIL st_bytes: got %h want 0010ef0011be", {wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]});
    end
    n_cmp++;
    if (wr_cyc[0] !== 1 || wr_cyc[1] !== 2) begin
      n_bad++; $display("FAIL st_wr_cycles: got %0d,%0d want 1,2", wr_cyc[0], wr_cyc[1]);
    end
    n_cmp++;
    if (busy_cnt !== 2) begin n_bad++; $display("FAIL st_busy_cnt: got %0d want 2", busy_cnt); end
    n_cmp++;
    if (a_dout !== 16'h0000) begin n_bad++; $display("FAIL st_dout_held: got %h want 0000", a_dout); end
  endtask

  task automatic test_load_word;
    a_txn(1'b0, 2'b00, 16'h0010, 16'h1234);
    n_cmp++;
    if (rdy_cyc !== 4) begin n_bad++; $display("FAIL ld_ready_cyc: got %0d want 4", rdy_cyc); end
    n_cmp++;
    if (a_dout !== 16'hBEEF) begin n_bad++; $display("FAIL ld_data: got %h want beef", a_dout); end
    n_cmp++;
    if (wr_cnt !== 0) begin n_bad++; $display("FAIL ld_no_write: got %0d writes want 0", wr_cnt); end
    n_cmp++;
    if (busy_cnt !== 3) begin n_bad++; $display("FAIL ld_busy_cnt: got %0d want 3", busy_cnt); end
  endtask

  task automatic test_size_clip;
    a_txn(1'b1, 2'b01, 16'h0020, 16'hC35A);
    n_cmp++;
    if (rdy_cyc !== 3 || wr_cnt !== 2) begin
      n_bad++; $display("FAIL clip_store: got ready %0d writes %0d want 3 2", rdy_cyc, wr_cnt);
    end
    a_txn(1'b0, 2'b01, 16'h0020, 16'h0000);
    n_cmp++;
    if (rdy_cyc !== 4 || a_dout !== 16'hC35A) begin
      n_bad++; $display("FAIL clip_load: got ready %0d data %h want 4 c35a", rdy_cyc, a_dout);
    end
    a_txn(1'b0, 2'b11, 16'h0021, 16'h0000);
    n_cmp++;
    if (rdy_cyc !== 3 || a_dout !== 16'h00C3) begin
      n_bad++; $display("FAIL byte_load: got ready %0d data %h want 3 00c3", rdy_cyc, a_dout);
    end
  endtask

  task automatic test_wrap;
    a_txn(1'b1, 2'b00, 16'hFFFF, 16'h1357);
`ifdef REFLET_BRIDGE_ALIGN_CHECK_EN
    n_cmp++;
    if (rdy_cyc !== 1 || err_at_rdy !== 1 || wr_cnt !== 0) begin
      n_bad++; $display("FAIL wrap_reject: got ready %0d err %0d writes %0d want 1 1 0", rdy_cyc, err_at_rdy, wr_cnt);
    end
`else
    n_cmp++;
    if (rdy_cyc !== 3 || wr_cnt !== 2) begin
      n_bad++; $display("FAIL wrap_cnt: got ready %0d writes %0d want 3 2", rdy_cyc, wr_cnt);
    end
    n_cmp++;
    if ({wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]} !== 48'hFFFF_57_0000_13) begin
      n_bad++; $display("FAIL wrap_bytes: got %h want ffff5700001 3", {wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]});
    end
    n_cmp++;
    if (mem_a[0] !== 8'h13) begin n_bad++; $display("FAIL wrap_mem0: got %h want 13", mem_a[0]); end
`endif
  endtask

  task automatic test_align;
    a_txn(1'b1, 2'b10, 16'h0003, 16'hA1B2);
`ifdef REFLET_BRIDGE_ALIGN_CHECK_EN
    n_cmp++;
    if (rdy_cyc !== 1 || err_at_rdy !== 1) begin
      n_bad++; $display("FAIL align_err: got ready %0d err %0d want 1 1", rdy_cyc, err_at_rdy);
    end
    n_cmp++;
    if (wr_cnt !== 0) begin n_bad++; $display("FAIL align_no_write: got %0d want 0", wr_cnt); end
`else
    n_cmp++;
    if (rdy_cyc !== 3 || err_at_rdy !== 0) begin
      n_bad++; $display("FAIL align_off: got ready %0d err %0d want 3 0", rdy_cyc, err_at_rdy);
    end
    n_cmp++;
    if ({wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]} !== 48'h0003_B2_0004_A1) begin
      n_bad++; $display("FAIL align_off_bytes: got %h want 0003b20004a1", {wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]});
    end
`endif
    n_cmp++;
    if (a_dout !== 16'h00C3) begin n_bad++; $display("FAIL align_dout_held: got %h want 00c3", a_dout); end
  endtask

  task automatic test_w32_load;
    b_txn(1'b1, 2'b00, 16'h0100, 32'h44332211);
    n_cmp++;
    if (rdy_cyc !== 5 || wr_cnt !== 4) begin
      n_bad++; $display("FAIL w32_store: got ready %0d writes %0d want 5 4", rdy_cyc, wr_cnt);
    end
    b_txn(1'b0, 2'b10, 16'h0100, 32'h0);
    n_cmp++;
    if (b_dout !== 32'h00002211) begin n_bad++; $display("FAIL w32_half: got %h want 00002211", b_dout); end
    n_cmp++;
    if (rdy_cyc !== 4 || busy_cnt !== 3 || wr_cnt !== 0) begin
      n_bad++; $display("FAIL w32_half_timing: got ready %0d busy %0d writes %0d want 4 3 0", rdy_cyc, busy_cnt, wr_cnt);
    end
    b_txn(1'b0, 2'b00, 16'h0100, 32'h0);
    n_cmp++;
    if (rdy_cyc !== 6 || b_dout !== 32'h44332211) begin
      n_bad++; $display("FAIL w32_word: got ready %0d data %h want 6 44332211", rdy_cyc, b_dout);
    end
  endtask

  task automatic test_reset_mid;
    int rdy_seen;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_size = 2'b01; b_addr = 16'h0200; b_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    b_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_ram_we !== 1'b1 || b_ram_addr !== 16'h0201) begin
      n_bad++; $display("FAIL mid_pre: got we %b addr %h want 1 0201", b_ram_we, b_ram_addr);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (b_ram_we !== 1'b0 || b_busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_abort: got we %b busy %b want 0 0", b_ram_we, b_busy);
    end
    rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b_ready) rdy_seen++;
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b_ready) rdy_seen++;
    end
    n_cmp++;
    if (rdy_seen !== 0) begin n_bad++; $display("FAIL mid_no_ready: got %0d pulses want 0", rdy_seen); end
    n_cmp++;
    if (mem_b[16'h0200] !== 8'h0D || mem_b[16'h0201] !== 8'h00) begin
      n_bad++; $display("FAIL mid_mem: got %h %h want 0d 00", mem_b[16'h0200], mem_b[16'h0201]);
    end
    b_txn(1'b1, 2'b01, 16'h0300, 32'h01020304);
    n_cmp++;
    if (rdy_cyc !== 5 || wr_cnt !== 4) begin
      n_bad++; $display("FAIL mid_recover: got ready %0d writes %0d want 5 4", rdy_cyc, wr_cnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_b[16'h0300] !== 8'h04 || mem_b[16'h0303] !== 8'h01) begin
      n_bad++; $display("FAIL mid_recover_mem: got %h %h want 04 01", mem_b[16'h0300], mem_b[16'h0303]);
    end
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_load_word;
    test_size_clip;
    test_wrap;
    test_align;
    test_w32_load;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reflet_mem_byte_bridge.md
Name: reflet_mem_byte_bridge

Overview:
- Memory-side responder for the Reflet CPU data port.
- Accepts one word-wide load or store request. The access size uses the CPU's reduced-behaviour encoding.
- Executes the access as a sequence of byte cycles on an 8-bit synchronous RAM, then returns zero-extended load data.
- Sits between the CPU's memory interface and byte-wide block RAM or external 8-bit memory.

Parameters:
- wordsize, 16, CPU word width in bits; must be 8, 16, 32 or 64.
- addrsize, 16, byte address width on both sides.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- write_en  input  1  1 = store, 0 = load; sampled with req.
- size_bits  input  2  00 = full word, 01 = 32-bit, 10 = 16-bit, 11 = 8-bit.
- addr  input  addrsize  byte address of the least significant byte.
- data_in  input  wordsize  store data from the CPU.
- data_out  output  wordsize  load result.
- busy  output  1  high from the cycle after an accepted req until ready.
- ready  output  1  one-cycle completion pulse.
- align_err  output  1  alignment fault pulse; see Optional Feature.
- ram_addr  output  addrsize  byte RAM address.
- ram_data_out  output  8  byte written to RAM.
- ram_write_en  output  1  RAM write strobe.
- ram_data_in  input  8  RAM read data; valid one cycle after ram_addr.

Behaviour:
- Reset (async, reset=0):
  - Force IDLE.
  - data_out=0, busy=0, ready=0, align_err=0.
  - ram_addr=0, ram_data_out=0, ram_write_en=0.
  - Reset mid-transfer aborts the transfer. ram_write_en drops immediately. No ready is emitted.
- Byte count N:
  - size_bits 00 gives N = wordsize/8.
  - 01 gives 4, 10 gives 2, 11 gives 1.
  - N is clipped to wordsize/8 when the size exceeds the word.
- Byte order: little-endian. Byte k uses address addr+k and data bits [8k+7:8k].
- Address arithmetic wraps modulo 2^addrsize.
- States: IDLE, XFER, RTAIL, DONE.
- IDLE:
  - On req=1, latch addr, data_in, write_en and N; set count=0; go to XFER.
  - req=0 keeps the block in IDLE.
  - req while busy is ignored and not queued.
- XFER (one byte per cycle):
  - Drive ram_addr = base+count.
  - Store: ram_write_en=1, ram_data_out = byte[count].
  - Load: ram_write_en=0. Capture ram_data_in into byte[count-1] when count>0.
  - At count = N-1, a store goes to DONE and a load goes to RTAIL. Otherwise count increments.
- RTAIL: capture the final byte N-1. ram_write_en=0. Go to DONE.
- DONE:
  - ready=1 for exactly one cycle, then go to IDLE.
  - For loads, data_out is updated on entry to DONE. Bytes >= N are 0. data_out holds until the next load completes.
  - Stores leave data_out unchanged.
- Latency, counted from the req cycle (cycle 0):
  - Store: ready in cycle N+1.
  - Load: ready in cycle N+2.
- busy=1 in XFER and RTAIL; 0 in IDLE and DONE. A new req is accepted in the cycle after ready.
- ram_write_en is 0 in every state other than a store XFER. No RAM write ever occurs during a load.

Optional Feature:
- Macro: REFLET_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - A req with N>1 and addr mod N != 0 is rejected.
  - Go directly IDLE -> DONE with no RAM cycle.
  - align_err=1 together with ready for one cycle; data_out is unchanged.
- Undefined:
  - Unaligned requests execute normally, with wrap-around as above.
  - align_err is tied to 0.

Test Plan:
- wordsize=16, store size 00, addr=0x0010, data_in=0xBEEF -> writes 0xEF@0x0010 in cycle 1 and 0xBE@0x0011 in cycle 2; ready in cycle 3.
- After the store above, load size 00 addr=0x0010 -> data_out=0xBEEF, ready in cycle 4, no ram_write_en pulse.
- wordsize=32, RAM preloaded 0x11,0x22,0x33,0x44 at 0x0100; load size 10 -> data_out=0x00002211, exactly 2 RAM reads.
- wordsize=16, size 01 load at 0x0020 -> N clipped to 2, data_out = 16-bit word from 0x0020/0x0021; addr=0xFFFF size 00 store -> second byte written to 0x0000.
- Assert reset low during store byte 1 of 4 -> ram_write_en drops same instant, busy=0, no ready; a fresh req after release completes normally.
- With REFLET_BRIDGE_ALIGN_CHECK_EN, size 10 store at addr=0x0003 -> no ram_write_en; ready and align_err both high in cycle 1. Same request without the macro -> writes 0x0003 and 0x0004.
